// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller: FSM states and digit limits.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0]  MAX_BCD_DIGIT    = 4'd9;
  localparam int unsigned DEFAULT_TICK_DIV = 50000000;

endpackage

// File: rtl/microwave_ctrl_tick_gen.sv
// Modulo-DIV counter with clear and count-enable; tick flags the wrap cycle.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic clrn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Combinational so the parent can register it into its own strobe.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (!clrn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave control FSM driving an mm:ss BCD countdown timer, magnetron and beeper.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int unsigned BEEP_SECS = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] data,
  output logic       loadn,
  output logic       timer_clr,
  output logic       timer_en,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  state_t st;
  logic   key_ok;
  logic   cook_run, beep_run;
  logic   cook_tick, beep_sec, beep_end;

  assign state  = st;
  assign key_ok = key_valid && (key_digit <= MAX_BCD_DIGIT);

  // Dividers only advance on cycles where the FSM stays in the same state,
  // so a pause holds the cook phase and an exit never emits a stray tick.
  always_comb begin
    cook_run = (st == COOK) && !clear && !stop && !timer_zero && door_closed;
    beep_run = (st == DONE) && !clear && !stop && door_closed;
  end

  tick_gen #(.DIV(TICK_DIV)) u_cook_div (
    .clock (clock),
    .clrn  (clrn),
    .clr   ((st != COOK) && (st != PAUSE)),
    .en    (cook_run),
    .tick  (cook_tick)
  );

  tick_gen #(.DIV(TICK_DIV)) u_beep_div (
    .clock (clock),
    .clrn  (clrn),
    .clr   (st != DONE),
    .en    (beep_run),
    .tick  (beep_sec)
  );

  tick_gen #(.DIV(BEEP_SECS)) u_beep_len (
    .clock (clock),
    .clrn  (clrn),
    .clr   (st != DONE),
    .en    (beep_sec),
    .tick  (beep_end)
  );

  always_ff @(posedge clock) begin
    if (!clrn) begin
      st        <= IDLE;
      data      <= '0;
      loadn     <= 1'b1;
      timer_clr <= 1'b0;
      timer_en  <= 1'b0;
      mag_on    <= 1'b0;
      beep      <= 1'b0;
    end else begin
      loadn     <= 1'b1;
      timer_clr <= 1'b0;
      timer_en  <= 1'b0;
      case (st)
        IDLE: begin
          if (clear) begin
            timer_clr <= 1'b1;
          end else if (key_ok) begin
            data  <= key_digit;
            loadn <= 1'b0;
            st    <= SETUP;
          end
        end
        SETUP: begin
          if (clear || stop) begin
            timer_clr <= 1'b1;
            st        <= IDLE;
          end else if (start && door_closed && !timer_zero) begin
            mag_on <= 1'b1;
            st     <= COOK;
          end else if (key_ok) begin
            data  <= key_digit;
            loadn <= 1'b0;
          end
        end
        COOK: begin
          if (clear) begin
            timer_clr <= 1'b1;
            mag_on    <= 1'b0;
            st        <= IDLE;
          end else if (stop) begin
            mag_on <= 1'b0;
            st     <= PAUSE;
          end else if (timer_zero) begin
            mag_on <= 1'b0;
            beep   <= 1'b1;
            st     <= DONE;
          end else if (!door_closed) begin
            mag_on <= 1'b0;
            st     <= PAUSE;
          end else begin
            timer_en <= cook_tick;
          end
        end
        PAUSE: begin
          if (clear || stop) begin
            timer_clr <= 1'b1;
            st        <= IDLE;
          end else if (start && door_closed) begin
            mag_on <= 1'b1;
            st     <= COOK;
          end
        end
        DONE: begin
          if (clear || stop || !door_closed || beep_end) begin
            beep <= 1'b0;
            st   <= IDLE;
          end
        end
        default: begin
          mag_on <= 1'b0;
          beep   <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

endmodule
